// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump engine: FSM encoding and
// default geometry of the register file being walked.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_NREG   = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/reg_dump_out_stage.sv
// Valid/ready output register for the dump stream: loads a word on request,
// holds it stable under backpressure, and drops it on consume or clear.
module dump_out_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  // NOTE: datapath registers are reset too, so the stream reads all-zero out
  // of reset rather than X; there is no memory here that would make this costly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_valid <= 1'b1;
      out_addr  <= load_addr;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_dump.sv
// Register-file readout engine: walks addresses 0..NREG-1 through the spare
// read port and streams {addr, data} words, holding CPU writes while busy.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] R_Addr,
  input  logic [DATA_W-1:0] R_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              hold_wr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] r_addr, r_addr_next;
  logic              load, handshake, is_last, done_next;

  assign is_last   = (idx == LAST_IDX);
  assign handshake = out_valid && out_ready;
  assign R_Addr    = r_addr;
  assign hold_wr   = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      r_addr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= next_state;
      idx    <= idx_next;
      r_addr <= r_addr_next;
      busy   <= (next_state != IDLE);
      done   <= done_next;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) next_state = RUN;
        RUN:     if (load && is_last) next_state = DRAIN;
        DRAIN:   if (handshake) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    load      = (state == RUN) && !abort && (!out_valid || out_ready);
    done_next = (state == DRAIN) && handshake && !abort;
    idx_next  = idx;
    if (state == IDLE && start && !abort) begin
      idx_next = '0;
    end else if (load && !is_last) begin
      idx_next = idx + 1'b1;
    end
    // Read address is registered so R_Data has a full cycle to settle.
    r_addr_next = (next_state == RUN) ? idx_next : '0;
  end

  dump_out_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .load      (load),
    .load_addr (idx),
    .load_data (R_Data),
    .load_last (is_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: stimulus pushes expected words, a negedge
// monitor pops and compares on every accepted word.
module tb_reg_dump;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] R_Addr, out_addr;
  logic [DW-1:0] R_Data, out_data;
  logic          out_valid, out_last, busy, hold_wr, done;

  logic [DW-1:0] regs [NREG];
  assign R_Data = regs[R_Addr];

  always #5 clk = ~clk;

  reg_dump #(.NREG(NREG), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .R_Addr    (R_Addr),
    .R_Data    (R_Data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .hold_wr   (hold_wr),
    .done      (done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  int   dc;
  int   n;
  logic [15:0] rdy_pat = 16'b1011_0110_1110_0101;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("word_addr", out_addr, mon_e.addr);
        check("word_data", out_data, mon_e.data);
        check("word_last", out_last, mon_e.last);
      end
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int i, input logic [DW-1:0] d);
    sb.push_back('{addr: AW'(i), data: d, last: (i == NREG - 1)});
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_word(i, 32'hA500_0000 + 32'(i));
  endtask

  task automatic load_regs();
    for (int i = 0; i < NREG; i++) regs[i] = 32'hA500_0000 + 32'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_word(input int a, input string name);
    int k = 0;
    while (!(out_valid && out_addr == AW'(a)) && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(out_valid && out_addr == AW'(a)), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    check(name, done, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    load_regs();
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hold_wr", hold_wr, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_r_addr", R_Addr, 5'd0);
    check("rst_out_addr", out_addr, 5'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    tick();

    // Full dump at one word per cycle.
    push_range(0, NREG - 1);
    dc = done_cnt;
    pulse_start();
    check("full_busy_k", busy, 1'b1);
    check("full_hold_k", hold_wr, 1'b1);
    check("full_valid_k", out_valid, 1'b0);
    tick();
    for (int i = 0; i < NREG; i++) begin
      check("full_valid", out_valid, 1'b1);
      check("full_busy", busy, 1'b1);
      check("full_last_flag", out_last, (i == NREG - 1));
      tick();
    end
    check("full_done", done, 1'b1);
    check("full_busy_end", busy, 1'b0);
    check("full_valid_end", out_valid, 1'b0);
    tick();
    check("full_done_pulse", done, 1'b0);
    check("full_done_count", 64'(done_cnt - dc), 64'd1);
    check("full_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset while idle clears the retained last word at once.
    rst_n = 1'b0;
    #1;
    check("async_out_addr", out_addr, 5'd0);
    check("async_out_data", out_data, 32'd0);
    check("async_busy", busy, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();

    // start and abort together while idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);
    tick();
    check("idle_abort_valid", out_valid, 1'b0);

    // Backpressure: stall on word 5, then an irregular ready pattern.
    push_range(0, NREG - 1);
    dc = done_cnt;
    pulse_start();
    wait_word(5, "bp_reach_5");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_addr", out_addr, 5'd5);
      check("bp_hold_data", out_data, 32'hA500_0005);
    end
    n = 0;
    while (!done && n < 300) begin
      out_ready = rdy_pat[n % 16];
      tick();
      n++;
    end
    check("bp_done", done, 1'b1);
    out_ready = 1'b1;
    tick();
    check("bp_done_count", 64'(done_cnt - dc), 64'd1);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Ignored second start at word 3, abort at word 10.
    push_range(0, 10);
    dc = done_cnt;
    pulse_start();
    wait_word(3, "ab_reach_3");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_still_busy", busy, 1'b1);
    wait_word(10, "ab_reach_10");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid", out_valid, 1'b0);
    check("ab_busy", busy, 1'b0);
    check("ab_hold_wr", hold_wr, 1'b0);
    check("ab_last", out_last, 1'b0);
    repeat (5) tick();
    check("ab_no_done", 64'(done_cnt - dc), 64'd0);
    check("ab_quiet", out_valid, 1'b0);
    check("ab_sb_empty", 64'(sb.size()), 64'd0);
    push_range(0, NREG - 1);
    pulse_start();
    wait_done("ab_restart_done");
    check("ab_restart_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a dump at word 17.
    push_range(0, 16);
    pulse_start();
    wait_word(17, "rs_reach_17");
    rst_n = 1'b0;
    #1;
    check("rs_valid", out_valid, 1'b0);
    check("rs_busy", busy, 1'b0);
    check("rs_out_addr", out_addr, 5'd0);
    check("rs_r_addr", R_Addr, 5'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rs_idle_valid", out_valid, 1'b0);
    check("rs_idle_busy", busy, 1'b0);
    check("rs_sb_empty", 64'(sb.size()), 64'd0);
    push_range(0, NREG - 1);
    pulse_start();
    wait_done("rs_restart_done");
    check("rs_restart_sb_empty", 64'(sb.size()), 64'd0);

    // Coherence with hold_wr ignored: late write shows, early write does not.
    load_regs();
    for (int i = 0; i < NREG; i++)
      push_word(i, (i == 20) ? 32'hDEAD_BEEF : 32'hA500_0000 + 32'(i));
    pulse_start();
    wait_word(3, "coh_reach_3");
    regs[2]  = 32'h1234_5678;
    regs[20] = 32'hDEAD_BEEF;
    wait_done("coh_done");
    check("coh_sb_empty", 64'(sb.size()), 64'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
